// File: rtl/fp_calc_pkg.sv
// rtl/fp_calc_pkg.sv - shared types and IEEE-754 single constants for the fp add issuer
package fp_calc_pkg;

    localparam int FP_WIDTH    = 32;
    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_HI   = 30;
    localparam int FP_EXP_LO   = 23;
    localparam int FP_FRAC_HI  = 22;

    localparam logic [FP_WIDTH-1:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]          FP_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        HOLD
    } state_t;

endpackage

// File: rtl/fp_special_detect.sv
// rtl/fp_special_detect.sv - classifies NaN/Inf/zero operands and forms the bypass result
module fp_special_detect
    import fp_calc_pkg::*;
(
    input  logic [FP_WIDTH-1:0] a,
    input  logic [FP_WIDTH-1:0] b,
    input  logic                sub,
    output logic                bypass,
    output logic [FP_WIDTH-1:0] result
);

    logic [FP_WIDTH-1:0] b_eff;
    logic a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // Subtraction is addition of B with its sign flipped.
    assign b_eff  = {b[FP_SIGN_BIT] ^ sub, b[FP_SIGN_BIT-1:0]};

    assign a_max  = (a[FP_EXP_HI:FP_EXP_LO] == FP_EXP_MAX);
    assign b_max  = (b[FP_EXP_HI:FP_EXP_LO] == FP_EXP_MAX);
    assign a_nan  = a_max && (a[FP_FRAC_HI:0] != '0);
    assign b_nan  = b_max && (b[FP_FRAC_HI:0] != '0);
    assign a_inf  = a_max && (a[FP_FRAC_HI:0] == '0);
    assign b_inf  = b_max && (b[FP_FRAC_HI:0] == '0);
    assign a_zero = (a[FP_SIGN_BIT-1:0] == '0);
    assign b_zero = (b[FP_SIGN_BIT-1:0] == '0);

    assign bypass = a_max || b_max || a_zero || b_zero;

    always_comb begin
        result = '0;
        if (a_nan || b_nan) begin
            result = FP_QNAN;
        end else if (a_inf && b_inf) begin
            result = (a[FP_SIGN_BIT] != b_eff[FP_SIGN_BIT]) ? FP_QNAN : a;
        end else if (a_inf) begin
            result = a;
        end else if (b_inf) begin
            result = b_eff;
        end else if (a_zero && b_zero) begin
            result = '0;
        end else if (a_zero) begin
            result = b_eff;
        end else begin
            result = a;
        end
    end

endmodule

// File: rtl/fp_add_issuer.sv
// rtl/fp_add_issuer.sv - sequences the fp addition stage load/compute protocol between valid/ready ports
// Optional FP_ISSUE_SPECIAL_EN: NaN/Inf/zero operands resolved locally without touching the stage.
module fp_add_issuer
    import fp_calc_pkg::*;
#(
    parameter int LOAD_CYCLES = 3,
    parameter int TIMEOUT     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [FP_WIDTH-1:0] op_a,
    input  logic [FP_WIDTH-1:0] op_b,
    input  logic                op_sub,
    output logic                add_en,
    output logic                add_load,
    output logic                add_pm,
    output logic [FP_WIDTH-1:0] add_a,
    output logic [FP_WIDTH-1:0] add_b,
    output logic                add_cin,
    input  logic [FP_WIDTH-1:0] add_sum,
    input  logic                add_cout,
    input  logic                add_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [FP_WIDTH-1:0] res_data,
    output logic                res_err
);

    localparam logic [7:0] LOAD_LAST    = 8'(LOAD_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t              state, state_n;
    logic [7:0]          cnt, cnt_n;
    logic                en_n, load_n, pm_n, valid_n, err_n;
    logic [FP_WIDTH-1:0] a_n, b_n, data_n;
    logic                cout_q;

`ifdef FP_ISSUE_SPECIAL_EN
    logic                bypass;
    logic [FP_WIDTH-1:0] bypass_result;

    fp_special_detect u_special (
        .a      (op_a),
        .b      (op_b),
        .sub    (op_sub),
        .bypass (bypass),
        .result (bypass_result)
    );
`endif

    assign op_ready = (state == IDLE);
    assign add_cin  = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            add_en    <= 1'b0;
            add_load  <= 1'b0;
            add_pm    <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            add_en    <= en_n;
            add_load  <= load_n;
            add_pm    <= pm_n;
            add_a     <= a_n;
            add_b     <= b_n;
            res_valid <= valid_n;
            res_data  <= data_n;
            res_err   <= err_n;
            cout_q    <= add_cout;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        en_n    = add_en;
        load_n  = add_load;
        pm_n    = add_pm;
        a_n     = add_a;
        b_n     = add_b;
        valid_n = res_valid;
        data_n  = res_data;
        err_n   = res_err;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    a_n   = op_a;
                    b_n   = op_b;
                    pm_n  = op_sub;
                    cnt_n = '0;
`ifdef FP_ISSUE_SPECIAL_EN
                    if (bypass) begin
                        data_n  = bypass_result;
                        err_n   = 1'b0;
                        valid_n = 1'b1;
                        state_n = HOLD;
                    end else
`endif
                    begin
                        en_n    = 1'b1;
                        load_n  = 1'b1;
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                if (cnt == LOAD_LAST) begin
                    load_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = WAIT;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            WAIT: begin
                // Ready seen at cnt 0 may be left over from the previous operation.
                if (add_ready && (cnt != '0)) begin
                    data_n  = add_sum;
                    err_n   = 1'b0;
                    valid_n = 1'b1;
                    state_n = HOLD;
                end else if (cnt == TIMEOUT_LAST) begin
                    data_n  = FP_QNAN;
                    err_n   = 1'b1;
                    valid_n = 1'b1;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_add_issuer.sv
// tb/tb_fp_add_issuer.sv - directed self-checking bench for fp_add_issuer with a behavioural stage model
module tb_fp_add_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        op_sub = 1'b0;
    logic        add_en, add_load, add_pm, add_cin;
    logic [31:0] add_a, add_b;
    logic [31:0] add_sum = 32'hDEADBEEF;
    logic        add_cout = 1'b0;
    logic        add_ready = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_add_issuer #(.LOAD_CYCLES(3), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .add_en    (add_en),
        .add_load  (add_load),
        .add_pm    (add_pm),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .add_ready (add_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    // Stage model: mode 0 ready stage_delay cycles after load falls, 1 never ready,
    // 2 ready stuck high with the fresh sum only from the second cycle after load.
    int          stage_mode = 0;
    int          stage_delay = 4;
    int          stage_cnt = 0;
    logic [31:0] stage_result = '0;

    always @(posedge clk) begin
        #2;
        if (add_load) stage_cnt = 0;
        else if (stage_cnt < 1000) stage_cnt++;
        case (stage_mode)
            0: begin
                add_ready = !add_load && (stage_cnt >= stage_delay);
                add_sum   = add_ready ? stage_result : 32'hDEADBEEF;
            end
            1: begin
                add_ready = 1'b0;
                add_sum   = 32'hDEADBEEF;
            end
            default: begin
                add_ready = 1'b1;
                add_sum   = (stage_cnt >= 2) ? stage_result : 32'hBAD0BAD0;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic b2b,
                          output logic accepted, output int lc, output int wc,
                          output logic rdy_hi, output logic stable_ok, output logic done);
        if (!b2b) @(negedge clk);
        op_a = a; op_b = b; op_sub = s; op_valid = 1'b1;
        accepted = op_ready;
        @(negedge clk);
        op_valid = 1'b0;
        lc = 0; wc = 0; rdy_hi = 1'b0; stable_ok = 1'b1; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (res_valid) begin
                done = 1'b1;
            end else begin
                if (op_ready) rdy_hi = 1'b1;
                if (add_a !== a || add_b !== b || add_pm !== s) stable_ok = 1'b0;
                if (add_load) lc++;
                else wc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    logic        acc, rdy_hi, stable_ok, done, hold_ok, seen_valid;
    int          lc, wc;
    logic [31:0] held;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_add_en", 32'(add_en), 32'd0);
        check("rst_add_load", 32'(add_load), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_add_cin", 32'(add_cin), 32'd0);
        check("rst_add_a", add_a, 32'h0);
        rst = 1'b0;

        // 6.75 + 3.0 = 9.75
        stage_mode = 0; stage_delay = 4; stage_result = 32'h411C0000;
        run_op(32'h40D80000, 32'h40400000, 1'b0, 1'b0, acc, lc, wc, rdy_hi, stable_ok, done);
        check("t1_accepted", 32'(acc), 32'd1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_load_cycles", 32'(lc), 32'd3);
        check("t1_wait_cycles", 32'(wc), 32'd4);
        check("t1_res_data", res_data, 32'h411C0000);
        check("t1_res_err", 32'(res_err), 32'd0);
        check("t1_operands_stable", 32'(stable_ok), 32'd1);
        check("t1_op_ready_low", 32'(rdy_hi), 32'd0);
        check("t1_add_en", 32'(add_en), 32'd1);
        check("t1_add_cin", 32'(add_cin), 32'd0);
        handshake();
        check("t1_valid_cleared", 32'(res_valid), 32'd0);
        check("t1_op_ready_back", 32'(op_ready), 32'd1);

        // 1.0 + -1.0 = 0, then 1.0 + 1.0 = 2.0 issued right after the handshake
        stage_result = 32'h00000000;
        run_op(32'h3F800000, 32'hBF800000, 1'b0, 1'b0, acc, lc, wc, rdy_hi, stable_ok, done);
        check("t2a_done", 32'(done), 32'd1);
        check("t2a_res_data", res_data, 32'h00000000);
        check("t2a_op_ready_low", 32'(rdy_hi), 32'd0);
        check("t2a_load_cycles", 32'(lc), 32'd3);
        handshake();
        stage_result = 32'h40000000;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, acc, lc, wc, rdy_hi, stable_ok, done);
        check("t2b_accepted", 32'(acc), 32'd1);
        check("t2b_done", 32'(done), 32'd1);
        check("t2b_res_data", res_data, 32'h40000000);
        check("t2b_add_en_held", 32'(add_en), 32'd1);
        handshake();

        // Stage never answers: timeout with quiet NaN
        stage_mode = 1;
        run_op(32'h40000000, 32'h3F800000, 1'b1, 1'b0, acc, lc, wc, rdy_hi, stable_ok, done);
        check("t3_done", 32'(done), 32'd1);
        check("t3_res_data", res_data, 32'h7FC00000);
        check("t3_res_err", 32'(res_err), 32'd1);
        check("t3_timeout_window", 32'(wc == 15 || wc == 16), 32'd1);
        check("t3_pm_stable", 32'(stable_ok), 32'd1);
        handshake();

        // Ready stuck high: stale ready at cnt 0 must be ignored
        stage_mode = 2; stage_result = 32'h40400000;
        run_op(32'h3F800000, 32'h40000000, 1'b0, 1'b0, acc, lc, wc, rdy_hi, stable_ok, done);
        check("t4_done", 32'(done), 32'd1);
        check("t4_res_data", res_data, 32'h40400000);
        check("t4_wait_cycles", 32'(wc), 32'd2);
        check("t4_res_err", 32'(res_err), 32'd0);

        // Downstream stalls 10 cycles in HOLD
        held = res_data;
        hold_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (res_data !== held || op_ready !== 1'b0 || res_valid !== 1'b1) hold_ok = 1'b0;
        end
        check("t5_hold_stable", 32'(hold_ok), 32'd1);
        handshake();
        check("t5_op_ready_after", 32'(op_ready), 32'd1);

        // Reset while in WAIT aborts silently
        stage_mode = 1;
        @(negedge clk);
        op_a = 32'h40800000; op_b = 32'h40800000; op_sub = 1'b0; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_in_wait_load", 32'(add_load), 32'd0);
        check("t6_in_wait_op_ready", 32'(op_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_op_ready", 32'(op_ready), 32'd1);
        check("t6_rst_add_en", 32'(add_en), 32'd0);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid) seen_valid = 1'b1;
        end
        check("t6_no_result", 32'(seen_valid), 32'd0);

`ifdef FP_ISSUE_SPECIAL_EN
        run_op(32'h7F800000, 32'hFF800000, 1'b0, 1'b0, acc, lc, wc, rdy_hi, stable_ok, done);
        check("sp1_res_data", res_data, 32'h7FC00000);
        check("sp1_load_cycles", 32'(lc), 32'd0);
        check("sp1_one_cycle", 32'(wc), 32'd0);
        check("sp1_res_err", 32'(res_err), 32'd0);
        handshake();
        run_op(32'h00000000, 32'h3C4A3FD5, 1'b0, 1'b0, acc, lc, wc, rdy_hi, stable_ok, done);
        check("sp2_res_data", res_data, 32'h3C4A3FD5);
        check("sp2_load_cycles", 32'(lc), 32'd0);
        handshake();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_add_issuer.md
Name: fp_add_issuer

Overview:
- Initiator-side controller for the 32-bit floating-point addition stage: the block that drives the stage's en/load/PlusOrMinus/A/B/cin inputs and consumes sumFinal/cout/ready.
- Accepts operand pairs over a valid/ready upstream interface and sequences the stage's multi-cycle load/compute protocol.
- Captures each result and presents it downstream over a valid/ready interface with a timeout error flag.
- Sits between the calculator's operand front-end and the result/display path.

Parameters:
- LOAD_CYCLES, 3, cycles add_load is held high per operation (1..15).
- TIMEOUT, 16, max cycles in WAIT before giving up (2..255).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- op_valid  in  1  upstream operand pair valid.
- op_ready  out  1  issuer can accept an operand pair.
- op_a  in  32  IEEE-754 single operand A.
- op_b  in  32  IEEE-754 single operand B.
- op_sub  in  1  1 = A-B, 0 = A+B.
- add_en  out  1  enable to addition stage.
- add_load  out  1  load strobe to addition stage.
- add_pm  out  1  PlusOrMinus to addition stage.
- add_a  out  32  operand A to stage.
- add_b  out  32  operand B to stage.
- add_cin  out  1  carry-in to stage, always 0.
- add_sum  in  32  sumFinal from stage.
- add_cout  in  1  cout from stage.
- add_ready  in  1  ready from stage.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  32  captured result.
- res_err  out  1  timeout occurred, qualified by res_valid.

Behaviour:
- Reset, synchronous active-high: all outputs 0 except op_ready = 1. State = IDLE, counters = 0. Reset mid-operation aborts without emitting a result, and add_load drops on the next edge.
- FSM states: IDLE, LOAD, WAIT, HOLD.
- IDLE:
  - op_ready = 1.
  - On op_valid, register op_a/op_b/op_sub into add_a/add_b/add_pm, set add_en = 1 and add_load = 1, clear cnt, go to LOAD.
- LOAD:
  - op_ready = 0; add_load held high for exactly LOAD_CYCLES cycles (cnt counts 0..LOAD_CYCLES-1).
  - Then add_load = 0, cnt = 0, go to WAIT.
  - add_ready is ignored in LOAD.
- WAIT:
  - cnt increments each cycle.
  - If add_ready = 1 and cnt >= 1: capture add_sum into res_data, res_err = 0, res_valid = 1, go to HOLD. The cnt >= 1 rule masks stale ready left over from the previous operation.
  - If cnt reaches TIMEOUT-1 with no ready: res_data = 32'h7FC00000, res_err = 1, res_valid = 1, go to HOLD.
  - If ready and timeout occur in the same cycle, ready wins.
- HOLD:
  - res_valid stays high; res_data and res_err are stable until res_ready = 1.
  - On handshake: res_valid = 0, go to IDLE; add_en stays 1.
  - No new operand is accepted until IDLE, so there is no overlap.
  - The earliest re-issue is the cycle after the handshake.
- Latency from op_valid&op_ready to res_valid: LOAD_CYCLES + 1 + (stage compute cycles) + 1.
- add_a/add_b/add_pm stay stable from LOAD through HOLD.
- add_cout is registered but unused by the result path.

Optional Feature:
- Macro: FP_ISSUE_SPECIAL_EN.
- Defined: in IDLE, operands with exponent 8'hFF or value ±0 bypass the stage. The result is computed in one cycle, going IDLE -> HOLD, with add_load never asserted:
  - NaN in either operand -> 7FC00000.
  - +Inf + -Inf (sign-adjusted for op_sub) -> 7FC00000.
  - Single Inf -> that Inf, with sign flipped if it is B and op_sub = 1.
  - ±0 op x -> x (B sign flipped for op_sub).
  - 0 op 0 -> +0.
  - res_err = 0 in all bypass cases.
- Undefined: all operands go through the stage.

Decomposition:
- Package fp_calc_pkg: state enum {IDLE, LOAD, WAIT, HOLD}, FP_QNAN = 32'h7FC00000, FP_EXP_MAX = 8'hFF, FP_WIDTH = 32, field-slice constants (sign 31, exp 30:23, frac 22:0).
- Sub-module fp_special_detect: combinational classifier plus bypass result, instantiated only under FP_ISSUE_SPECIAL_EN.

Test Plan:
- op_a = 40D80000, op_b = 40400000, op_sub = 0, stage model ready 4 cycles after load low -> add_load high exactly 3 cycles, res_data = 411C0000, res_err = 0.
- op_a = 3F800000, op_b = BF800000 -> res_data = 00000000; then op_a = op_b = 3F800000 issued back-to-back -> res_data = 40000000, op_ready low throughout the first operation.
- Stage model never asserts ready -> res_valid after TIMEOUT-1 WAIT cycles, res_data = 7FC00000, res_err = 1.
- Stage ready held high from the previous operation -> not accepted at WAIT cnt = 0, result taken at cnt = 1.
- res_ready low 10 cycles in HOLD -> res_data stable, op_ready = 0, then the handshake returns to IDLE; rst pulsed in WAIT -> res_valid never asserted, op_ready = 1 the next cycle.
- With FP_ISSUE_SPECIAL_EN: op_a = 7F800000, op_b = FF800000 -> 7FC00000 in 1 cycle, add_load never high; op_a = 00000000, op_b = 3C4A3FD5 -> 3C4A3FD5.
